seg_write_sched: RTL and testbench
==================================

# seg_write_sched

Memory-mapped write scheduler for the seven-segment / LED output path. Decodes CPU store strobes to the display and LED addresses and holds the LED word. Hex writes go straight to the eight digit registers. Decimal writes are converted by a sequential 32-cycle double-dabble engine, with a one-deep pending buffer, instead of a combinational divide chain. Sits between the CPU store path and the per-digit segment decoders / VGA renderer, which consume `s1`..`s8` unchanged.

## Interface
- `ADDR_HEX`, 32'hFFFF_FFF0: raw hex display write.
- `ADDR_LED`, 32'hFFFF_FFC2: LED word write.
- `ADDR_DEC`, 32'hFFFF_FFC4: unsigned decimal display write.
- `ADDR_DECNEG`, 32'hFFFF_FFC6: negative decimal display write (magnitude operand).
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  single-cycle store strobe.
- `address`  in  32  store address, valid with `wr_en`.
- `writeData`  in  32  store data, valid with `wr_en`.
- `s1`..`s8`  out  5 each  digit codes, `s1` most significant. 0–15 is a hex/decimal glyph; 5'h10 is the minus glyph.
- `dataOut`  out  16  held LED word.
- `busy`  out  1  conversion engine active.
- `done`  out  1  one-cycle pulse on every digit-register update.
- `overrun`  out  1  sticky; a pending display write was overwritten.

## Operation
- Writes are accepted only when `wr_en`=1; unmapped addresses are ignored.
- LED write: `dataOut` <= `writeData[15:0]` at the accepting edge. This is independent of `busy` and never queued.
- Display write (HEX/DEC/DECNEG) is called a job. A job is started if the engine is IDLE and the pending buffer is empty. Otherwise it is stored in pending (address class + 32-bit data).
  - If pending is already full, the new job replaces it and `overrun` <= 1.
- HEX job start: at the start edge, `sK` <= {1'b0, nibble}, with `s1` from bits [31:28] through `s8` from bits [3:0]. `done` pulses; engine stays IDLE.
- DEC/DECNEG job start: capture operand into the shift register, clear the 40-bit BCD accumulator, set bit counter = 0, and move to CONV.
- CONV (32 cycles): each cycle, every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left 1, then counter+1.
- On the 32nd CONV edge, the lower 8 BCD digits go to `s1`..`s8`; upper 2 are discarded, so the display shows value mod 10^8. `done` pulses and the engine returns to IDLE.
  - DECNEG: `s1` <= 5'h10; `s2`..`s8` take the lower 7 BCD digits (value mod 10^7).
- IDLE with pending full: the pending job starts at the next edge; HEX completes at that edge.
  - A simultaneous new display `wr_en` in that cycle goes into pending; it is not dropped and does not set `overrun`.
- States: IDLE, CONV. Only IDLE→CONV (DEC/DECNEG start) and CONV→IDLE (counter hits 31) transitions exist.
- Digit registers hold their value between jobs.

## Timing
- Reset values: `s1`..`s8`=0, `dataOut`=0, `busy`=0, `done`=0, `overrun`=0, pending empty, state IDLE.
- Reset asserted mid-conversion aborts the job immediately; partial results never reach the digits.
- HEX/LED latency: outputs change at the accepting edge (visible the cycle after `wr_en`).
- DEC/DECNEG latency: start at edge E0, then `busy`=1 for exactly 32 cycles. Digits update and `done`=1 at edge E32. `busy`=0 after E32.
- Back-to-back DEC jobs: the second starts at E33, so throughput is 1 job per 33 cycles.
- `busy` is registered: high iff state = CONV.

## Test plan
- Reset, then DEC write 12345678 → `busy` high 32 cycles; at E32 `s1`..`s8`=1,2,3,4,5,6,7,8 and a single `done` pulse.
- DEC write 32'hFFFF_FFFF → digits 9,4,9,6,7,2,9,5 (4294967295 mod 10^8); DECNEG write 42 → `s1`=5'h10, `s2`..`s8`=0,0,0,0,0,4,2.
- HEX write 32'hDEAD_BEEF while IDLE → next cycle digits D,E,A,D,B,E,E,F and `done`=1; `busy` stays 0. Then LED write 16'hA5A5 during a conversion → `dataOut`=16'hA5A5 next cycle; conversion is unaffected.
- DEC 111 then (during CONV) DEC 222 then DEC 333 → 222 is replaced and `overrun`=1. The first result shows 111; the next job starts at E33 and shows 333.
- Assert `rst` at conversion cycle 15 → all outputs return to reset values asynchronously; after release, digits stay 0 and no `done` pulse occurs.
- Write to 32'hFFFF_FFC8 → no output change, no `done`, `busy`=0.

Source files
------------

// File: rtl/seg_write_sched.sv
// Store-path scheduler for the seven-segment digits and LED word.
// Hex writes land directly; decimal writes run a 32-cycle double-dabble with a one-deep pending slot.
module seg_write_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [4:0]  s1,
  output logic [4:0]  s2,
  output logic [4:0]  s3,
  output logic [4:0]  s4,
  output logic [4:0]  s5,
  output logic [4:0]  s6,
  output logic [4:0]  s7,
  output logic [4:0]  s8,
  output logic [15:0] dataOut,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  localparam logic [31:0] ADDR_HEX    = 32'hFFFF_FFF0;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_FFC2;
  localparam logic [31:0] ADDR_DEC    = 32'hFFFF_FFC4;
  localparam logic [31:0] ADDR_DECNEG = 32'hFFFF_FFC6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  localparam logic [1:0] C_HEX = 2'd0;
  localparam logic [1:0] C_DEC = 2'd1;
  localparam logic [1:0] C_NEG = 2'd2;

  logic [0:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      bin_q, bin_d;
  logic [39:0]      bcd_q, bcd_d;
  logic             neg_q, neg_d;
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_cls_q, pend_cls_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [7:0][4:0]  dig_q, dig_d;
  logic [15:0]      led_q, led_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  logic        is_disp, is_led, job_go;
  logic [1:0]  wr_cls, job_cls;
  logic [31:0] job_data;
  logic [39:0] bcd_adj, bcd_sh;
  logic [31:0] bin_sh;

  always_comb begin
    is_disp = 1'b0;
    wr_cls  = C_HEX;
    if (wr_en) begin
      case (address)
        ADDR_HEX:    begin is_disp = 1'b1; wr_cls = C_HEX; end
        ADDR_DEC:    begin is_disp = 1'b1; wr_cls = C_DEC; end
        ADDR_DECNEG: begin is_disp = 1'b1; wr_cls = C_NEG; end
        default:     ;
      endcase
    end
  end

  assign is_led = wr_en && (address == ADDR_LED);

  // One double-dabble step: add-3 on every nibble >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++)
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
  end

  assign bcd_sh = {bcd_adj[38:0], bin_q[31]};
  assign bin_sh = {bin_q[30:0], 1'b0};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    pend_vld_d  = pend_vld_q;
    pend_cls_d  = pend_cls_q;
    pend_data_d = pend_data_q;
    dig_d       = dig_q;
    led_d       = led_q;
    done_d      = 1'b0;
    ovr_d       = ovr_q;
    job_go      = 1'b0;
    job_cls     = wr_cls;
    job_data    = writeData;

    if (is_led) led_d = writeData[15:0];

    if (state_q == S_IDLE) begin
      if (pend_vld_q) begin
        // Drain pending; a same-cycle display write refills the slot without overrun.
        job_go      = 1'b1;
        job_cls     = pend_cls_q;
        job_data    = pend_data_q;
        pend_vld_d  = is_disp;
        pend_cls_d  = wr_cls;
        pend_data_d = writeData;
      end else if (is_disp) begin
        job_go = 1'b1;
      end
    end else begin
      bcd_d = bcd_sh;
      bin_d = bin_sh;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        for (int k = 0; k < 8; k++) dig_d[k] = {1'b0, bcd_sh[(7-k)*4 +: 4]};
        if (neg_q) dig_d[0] = 5'h10;
      end
      if (is_disp) begin
        pend_vld_d  = 1'b1;
        pend_cls_d  = wr_cls;
        pend_data_d = writeData;
        if (pend_vld_q) ovr_d = 1'b1;
      end
    end

    if (job_go) begin
      if (job_cls == C_HEX) begin
        for (int k = 0; k < 8; k++) dig_d[k] = {1'b0, job_data[(7-k)*4 +: 4]};
        done_d = 1'b1;
      end else begin
        state_d = S_CONV;
        bin_d   = job_data;
        bcd_d   = 40'd0;
        cnt_d   = 5'd0;
        neg_d   = (job_cls == C_NEG);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      bin_q       <= 32'd0;
      bcd_q       <= 40'd0;
      neg_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_cls_q  <= C_HEX;
      pend_data_q <= 32'd0;
      dig_q       <= '0;
      led_q       <= 16'd0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      pend_vld_q  <= pend_vld_d;
      pend_cls_q  <= pend_cls_d;
      pend_data_q <= pend_data_d;
      dig_q       <= dig_d;
      led_q       <= led_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign {s1, s2, s3, s4} = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
  assign {s5, s6, s7, s8} = {dig_q[4], dig_q[5], dig_q[6], dig_q[7]};
  assign dataOut = led_q;
  assign busy    = (state_q == S_CONV);
  assign done    = done_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_seg_write_sched.sv
// Randomized bench for seg_write_sched; expected digits come from plain decimal/hex arithmetic.
module tb_seg_write_sched;
  logic        clk, rst, wr_en;
  logic [31:0] address, writeData;
  logic [4:0]  s1, s2, s3, s4, s5, s6, s7, s8;
  logic [15:0] dataOut;
  logic        busy, done, overrun;

  int nvec = 0;
  int nerr = 0;

  localparam logic [31:0] A_HEX = 32'hFFFF_FFF0;
  localparam logic [31:0] A_LED = 32'hFFFF_FFC2;
  localparam logic [31:0] A_DEC = 32'hFFFF_FFC4;
  localparam logic [31:0] A_NEG = 32'hFFFF_FFC6;

  seg_write_sched dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .address(address), .writeData(writeData),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6), .s7(s7), .s8(s8),
    .dataOut(dataOut), .busy(busy), .done(done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] digits();
    return {s1, s2, s3, s4, s5, s6, s7, s8};
  endfunction

  // cls: 0 hex, 1 decimal, 2 negative decimal
  function automatic logic [39:0] model(int cls, logic [31:0] d);
    logic [39:0] r;
    longint v;
    r = '0;
    if (cls == 0) begin
      for (int k = 0; k < 8; k++) r[k*5 +: 5] = {1'b0, d[k*4 +: 4]};
    end else begin
      v = longint'(d);
      v = (cls == 2) ? v % 10000000 : v % 100000000;
      for (int k = 0; k < 8; k++) begin
        r[k*5 +: 5] = 5'(v % 10);
        v = v / 10;
      end
      if (cls == 2) r[39:35] = 5'h10;
    end
    return r;
  endfunction

  function automatic logic [31:0] addr_of(int cls);
    return (cls == 0) ? A_HEX : (cls == 1) ? A_DEC : A_NEG;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one store now; it is accepted at the next edge, return 1 after that edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; address = a; writeData = d;
    @(posedge clk); #1;
    wr_en = 1'b0; address = 32'd0; writeData = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called at E(cur_e)+1 of a conversion; walks to E32+1 and checks the result.
  task automatic finish_conv(input int cur_e, input logic [39:0] exp, input string name);
    for (int e = cur_e; e <= 31; e++) begin
      nvec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        nerr++;
        $display("FAIL %s cyc%0d busy/done got %b%b want 10", name, e, busy, done);
      end
      step();
    end
    nvec++;
    if (digits() !== exp || done !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s result digits %h done %b busy %b want %h 1 0", name, digits(), done, busy, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; address = 32'd0; writeData = 32'd0;
    #1 rst = 1'b1;
    #2;
    nvec++;
    if (digits() !== 40'd0 || dataOut !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      nerr++;
      $display("FAIL reset digits %h led %h b%b d%b o%b want all zero", digits(), dataOut, busy, done, overrun);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_dec();
    wr(A_DEC, 32'd12345678);
    finish_conv(0, model(1, 32'd12345678), "dec12345678");
    step();
    nvec++;
    if (done !== 1'b0) begin nerr++; $display("FAIL dec_done_single got %b want 0", done); end
    wr(A_DEC, 32'hFFFF_FFFF);
    finish_conv(0, 40'h4A4D_9C94_A5 & 40'h0 | model(1, 32'hFFFF_FFFF), "dec_max");
    nvec++;
    if (digits() !== {5'd9, 5'd4, 5'd9, 5'd6, 5'd7, 5'd2, 5'd9, 5'd5}) begin
      nerr++; $display("FAIL dec_max_const got %h want 94967295", digits());
    end
    wr(A_NEG, 32'd42);
    finish_conv(0, {5'h10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd2}, "decneg42");
  endtask

  task automatic test_hex_led();
    wr(A_HEX, 32'hDEAD_BEEF);
    nvec++;
    if (digits() !== {5'hD, 5'hE, 5'hA, 5'hD, 5'hB, 5'hE, 5'hE, 5'hF} || done !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL hex_deadbeef digits %h done %b busy %b", digits(), done, busy);
    end
    step();
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL hex_after done %b busy %b want 0 0", done, busy); end
    wr(A_DEC, 32'd7654321);
    step(); step(); step();
    wr(A_LED, 32'h1234_A5A5);
    nvec++;
    if (dataOut !== 16'hA5A5) begin nerr++; $display("FAIL led_during_conv got %h want a5a5", dataOut); end
    finish_conv(4, model(1, 32'd7654321), "conv_with_led");
  endtask

  task automatic test_overrun();
    wr(A_DEC, 32'd111);
    wr(A_DEC, 32'd222);
    nvec++;
    if (overrun !== 1'b0) begin nerr++; $display("FAIL overrun_early got %b want 0", overrun); end
    wr(A_DEC, 32'd333);
    nvec++;
    if (overrun !== 1'b1) begin nerr++; $display("FAIL overrun_set got %b want 1", overrun); end
    finish_conv(2, model(1, 32'd111), "ovr_first");
    step();
    finish_conv(0, model(1, 32'd333), "ovr_second");
    nvec++;
    if (overrun !== 1'b1) begin nerr++; $display("FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr(A_DEC, 32'd111);
    for (int e = 0; e < 31; e++) step();
    wr(A_DEC, 32'd222);
    nvec++;
    if (digits() !== model(1, 32'd111) || done !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL b2b_first digits %h done %b busy %b", digits(), done, busy);
    end
    wr(A_DEC, 32'd333);
    nvec++;
    if (busy !== 1'b1 || done !== 1'b0 || overrun !== 1'b0) begin
      nerr++; $display("FAIL b2b_start busy %b done %b ovr %b want 1 0 0", busy, done, overrun);
    end
    finish_conv(0, model(1, 32'd222), "b2b_second");
    step();
    finish_conv(0, model(1, 32'd333), "b2b_third");
    nvec++;
    if (overrun !== 1'b0) begin nerr++; $display("FAIL b2b_no_overrun got %b want 0", overrun); end
  endtask

  task automatic test_random();
    int cls;
    logic [31:0] d;
    logic [15:0] led;
    for (int i = 0; i < 16; i++) begin
      cls = int'($urandom_range(0, 2));
      d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 99999));
      wr(addr_of(cls), d);
      if (cls == 0) begin
        nvec++;
        if (digits() !== model(0, d) || done !== 1'b1 || busy !== 1'b0) begin
          nerr++; $display("FAIL rand_hex %h digits %h want %h", d, digits(), model(0, d));
        end
        step();
      end else begin
        finish_conv(0, model(cls, d), "rand_dec");
      end
      led = 16'($urandom);
      wr(A_LED, {16'($urandom), led});
      nvec++;
      if (dataOut !== led) begin nerr++; $display("FAIL rand_led got %h want %h", dataOut, led); end
    end
  endtask

  task automatic test_unmapped();
    wr(A_LED, 32'h0000_3C3C);
    wr(A_HEX, 32'h0123_4567);
    step();
    wr(32'hFFFF_FFC8, 32'hFFFF_FFFF);
    nvec++;
    if (digits() !== model(0, 32'h0123_4567) || done !== 1'b0 || busy !== 1'b0 || dataOut !== 16'h3C3C) begin
      nerr++; $display("FAIL unmapped digits %h done %b busy %b led %h", digits(), done, busy, dataOut);
    end
  endtask

  task automatic test_reset_mid();
    wr(A_DEC, 32'd12345678);
    for (int e = 0; e < 15; e++) step();
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (digits() !== 40'd0 || dataOut !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      nerr++; $display("FAIL reset_mid digits %h led %h b%b d%b o%b want zero", digits(), dataOut, busy, done, overrun);
    end
    @(negedge clk); rst = 1'b0;
    for (int e = 0; e < 40; e++) begin
      step();
      nvec++;
      if (digits() !== 40'd0 || done !== 1'b0 || busy !== 1'b0) begin
        nerr++; $display("FAIL reset_mid_after cyc%0d digits %h done %b busy %b", e, digits(), done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dec();
    test_hex_led();
    test_overrun();
    test_back_to_back();
    test_random();
    test_unmapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
